// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and legal range of N.
package truth_table_sweeper_pkg;

  // Legal number of function inputs
  localparam int N_MIN = 1;
  localparam int N_MAX = 6;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of minterms for an n-input function
  function automatic int num_minterms(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/minterm_counter.sv
// Minterm index register: clears on sweep start, advances on each transfer,
// and flags the final minterm so the controller can finish without wrapping.
module minterm_counter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         last
);

  // Index register; clear has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + N'(1);
  end

  // All-ones index is the last minterm of the table
  assign last = (count == {N{1'b1}});

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every minterm of an N-input truth table, presenting (idx, s) on a
// valid/ready stream, counting the ones delivered, and pulsing done at the end.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [num_minterms(N)-1:0] tt,
  input  logic                     invert,
  input  logic                     ready,
  output logic                     valid,
  output logic [N-1:0]             idx,
  output logic                     s,
  output logic                     busy,
  output logic                     done,
  output logic [N:0]               ones
);

  localparam int W = num_minterms(N);

  // Reject illegal widths at elaboration rather than building a broken mux
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("truth_table_sweeper: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
  end

  state_t         state;
  logic [W-1:0]   tt_q;
  logic           inv_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;
  logic [N:0]     ones_q;
  logic           accept;
  logic           xfer;
  logic           last;
  logic           s_raw;

  // Start is only honoured from IDLE; a transfer is a valid/ready handshake
  assign accept = (state == IDLE) && start;
  assign xfer   = valid_q && ready;

  minterm_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (xfer),
    .count (idx),
    .last  (last)
  );

  // Table lookup uses only the latched copies so mid-sweep input changes are invisible
  assign s_raw = tt_q[idx] ^ inv_q;
  assign s     = valid_q & s_raw;

  // Sweep controller with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tt_q    <= '0;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            tt_q    <= tt;
            inv_q   <= invert;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= SWEEP;
          end
        end
        SWEEP: begin
          // Leave on the final handshake so idx never shows a wrap while valid
          if (xfer && last) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Ones accumulator; N+1 bits holds the all-ones count 2^N without overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ones_q <= '0;
    else if (accept) ones_q <= '0;
    else if (xfer)   ones_q <= ones_q + (N+1)'(s_raw);
  end

  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ones  = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: an N=2 instance checked against a
// scoreboard of expected (idx, s) transfers, plus an N=4 instance for width.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, invert, ready;
  logic [3:0] tt;
  logic       valid, s, busy, done;
  logic [1:0] idx;
  logic [2:0] ones;

  logic        start4;
  logic [15:0] tt4;
  logic        valid4, s4, busy4, done4;
  logic [3:0]  idx4;
  logic [4:0]  ones4;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int xfer4 = 0;
  bit done_seen, done4_seen;

  typedef struct packed { logic [1:0] idx; logic s; } exp_t;
  exp_t sb[$];

  truth_table_sweeper #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .tt(tt), .invert(invert),
    .ready(ready), .valid(valid), .idx(idx), .s(s), .busy(busy),
    .done(done), .ones(ones)
  );

  truth_table_sweeper #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .tt(tt4), .invert(invert),
    .ready(ready), .valid(valid4), .idx(idx4), .s(s4), .busy(busy4),
    .done(done4), .ones(ones4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle; a handshake seen here completes at the next edge
  task automatic sample();
    exp_t e;
    if (!rst_n) return;
    if (done)  begin done_cnt++; done_seen = 1'b1; end
    if (done4) done4_seen = 1'b1;
    if (valid && ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_underflow: observed transfer idx=%0d expected none", idx);
      end else begin
        e = sb.pop_front();
        chk("xfer_idx", 32'(idx), 32'(e.idx));
        chk("xfer_s", 32'(s), 32'(e.s));
      end
    end
    if (valid4 && ready) begin
      chk("n4_idx", 32'(idx4), 32'(xfer4));
      chk("n4_s", 32'(s4), 32'd1);
      xfer4++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] t, input logic inv);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.idx = 2'(k);
      e.s   = t[k] ^ inv;
      sb.push_back(e);
    end
  endtask

  // Returns with the start edge just past, i.e. in the first valid cycle
  task automatic start_sweep(input logic [3:0] t, input logic inv);
    tt = t; invert = inv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles (first valid cycle = 1) until done is sampled; bounded
  task automatic wait_done(input bit wide, output int n);
    n = 0;
    done_seen = 1'b0;
    done4_seen = 1'b0;
    while (!(wide ? done4_seen : done_seen) && n < 60) begin
      tick();
      n++;
    end
    if (!(wide ? done4_seen : done_seen)) begin
      tests++;
      fails++;
      $error("FAIL done_timeout: observed no done after %0d cycles expected done", n);
    end
  endtask

  initial begin
    int n, dc;
    rst_n = 1'b0; start = 1'b0; invert = 1'b0; ready = 1'b1; tt = '0;
    start4 = 1'b0; tt4 = '0;
    #3;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_done",  32'(done),  0);
    chk("rst_idx",   32'(idx),   0);
    chk("rst_s",     32'(s),     0);
    chk("rst_ones",  32'(ones),  0);
    chk("rst_ones4", 32'(ones4), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic sweep
    push_exp(4'b1101, 1'b0);
    start_sweep(4'b1101, 1'b0);
    chk("basic_first_valid", 32'(valid), 1);
    chk("basic_busy", 32'(busy), 1);
    wait_done(1'b0, n);
    chk("basic_done_cycle", 32'(n), 32'd5);
    chk("basic_done_len", 32'(done), 0);
    chk("basic_valid_after", 32'(valid), 0);
    chk("basic_busy_after", 32'(busy), 0);
    chk("basic_ones", 32'(ones), 3);
    chk("basic_drained", 32'(sb.size()), 0);
    tick(); tick(); tick();
    chk("basic_ones_hold", 32'(ones), 3);

    // Inverted sweep
    push_exp(4'b1101, 1'b1);
    start_sweep(4'b1101, 1'b1);
    wait_done(1'b0, n);
    chk("inv_done_cycle", 32'(n), 32'd5);
    chk("inv_ones", 32'(ones), 1);
    chk("inv_drained", 32'(sb.size()), 0);

    // Backpressure at idx=2
    push_exp(4'b1101, 1'b0);
    start_sweep(4'b1101, 1'b0);
    tick(); tick();
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_idx", 32'(idx), 2);
      chk("bp_s", 32'(s), 1);
      chk("bp_ones", 32'(ones), 1);
      chk("bp_valid", 32'(valid), 1);
      tick();
    end
    ready = 1'b1;
    wait_done(1'b0, n);
    chk("bp_ones_final", 32'(ones), 3);
    chk("bp_drained", 32'(sb.size()), 0);

    // Start and table changes mid-sweep are ignored
    push_exp(4'b1101, 1'b0);
    start_sweep(4'b1101, 1'b0);
    tick();
    start = 1'b1; tt = 4'b0000; invert = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, n);
    chk("ign_ones", 32'(ones), 3);
    chk("ign_drained", 32'(sb.size()), 0);
    tick();
    chk("ign_no_restart", 32'(valid), 0);

    // Reset mid-sweep at idx=1
    push_exp(4'b1101, 1'b0);
    start_sweep(4'b1101, 1'b0);
    tick();
    chk("mid_idx_before", 32'(idx), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(valid), 0);
    chk("mid_busy",  32'(busy),  0);
    chk("mid_done",  32'(done),  0);
    chk("mid_idx",   32'(idx),   0);
    chk("mid_s",     32'(s),     0);
    chk("mid_ones",  32'(ones),  0);
    sb.delete();
    dc = done_cnt;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mid_no_done", 32'(done_cnt), 32'(dc));
    push_exp(4'b0110, 1'b0);
    start_sweep(4'b0110, 1'b0);
    chk("mid_restart_idx", 32'(idx), 0);
    wait_done(1'b0, n);
    chk("mid_restart_ones", 32'(ones), 2);
    chk("mid_restart_drained", 32'(sb.size()), 0);
    chk("total_done_pulses", 32'(done_cnt), 32'd5);

    // N=4 all-ones table
    tt4 = 16'hFFFF; invert = 1'b0; xfer4 = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done(1'b1, n);
    chk("n4_done_cycle", 32'(n), 32'd17);
    chk("n4_transfers", 32'(xfer4), 32'd16);
    chk("n4_ones", 32'(ones4), 32'h10);
    chk("n4_valid_after", 32'(valid4), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N, default 2, number of function inputs (legal 1..6).
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have the port start, input, 1 bit: begin a sweep (sampled in IDLE only).
REQ-005 SHALL have the port tt, input, 2^N bits: truth table; bit k = function value for minterm k.
REQ-006 SHALL have the port invert, input, 1 bit: complement every output value (NOR-form evaluation).
REQ-007 SHALL have the port ready, input, 1 bit: consumer accepts the current minterm.
REQ-008 SHALL have the port valid, output, 1 bit: idx/s hold a minterm result.
REQ-009 SHALL have the port idx, output, N bits: current minterm number, which is also the input vector {a,b,...} MSB-first.
REQ-010 SHALL have the port s, output, 1 bit: function value for idx.
REQ-011 SHALL have the port busy, output, 1 bit: sweep in progress.
REQ-012 SHALL have the port done, output, 1 bit: one-cycle pulse after the last minterm transfers.
REQ-013 SHALL have the port ones, output, N+1 bits: count of transferred minterms with s=1.

Function
REQ-014 SHALL implement the states IDLE, SWEEP and DONE.
REQ-015 IDLE with start=1 SHALL latch tt and invert into internal registers, clear idx and ones, and enter SWEEP.
REQ-016 SWEEP SHALL drive valid=1, busy=1, and s = tt_latched[idx] XOR invert_latched.
REQ-017 A transfer SHALL occur on each cycle with valid=1 and ready=1; a transfer adds s to ones and increments idx.
REQ-018 While valid=1 and ready=0, idx, s and ones SHALL remain stable.
REQ-019 A transfer at idx = 2^N-1 SHALL enter DONE with no wrap of idx visible while valid=1.
REQ-020 DONE SHALL last exactly one cycle with done=1, valid=0, busy=0, then return to IDLE.
REQ-021 ones SHALL hold its final value until the next accepted start.
REQ-022 start while in SWEEP or DONE SHALL be ignored.
REQ-023 Changes on tt or invert during a sweep SHALL have no effect.
REQ-024 Latency SHALL be as follows: first valid in the cycle after the start edge; with ready held at 1, the sweep completes in 2^N cycles, and done asserts in cycle 2^N+1 after start.
REQ-025 ones SHALL never overflow, since its width is N+1 and its maximum is 2^N.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, independent of clk:
- state IDLE
- valid=0, busy=0, done=0
- idx=0, s=0, ones=0
- latched tt and invert cleared
REQ-027 Reset mid-sweep SHALL abandon the sweep without a done pulse.
REQ-028 The first start after reset release SHALL behave as in REQ-015.

Structure
REQ-029 A shared package SHALL hold:
- the state encoding constants IDLE/SWEEP/DONE
- the limits N_MIN=1 and N_MAX=6
REQ-030 The index register and its increment/last-detect logic SHALL be a sub-module, minterm_counter, with these ports: clk, rst_n, clr, en, count, last.
REQ-031 The latched-table mux and ones accumulator SHALL remain in the top module.

Verification
REQ-032 Basic sweep: N=2, tt=4'b1101, invert=0, ready=1, start pulse -> transfers (idx,s) = (0,1),(1,0),(2,1),(3,1); done one cycle later; ones=3.
REQ-033 Inverted sweep: the same stimulus with invert=1 -> s sequence 0,1,0,0; ones=1.
REQ-034 Backpressure: ready low for 3 cycles at idx=2 -> idx=2 and s=1 held stable; no count change; ones=3 at completion.
REQ-035 Ignored inputs: start re-pulsed and tt changed to 4'b0000 mid-sweep -> no restart; original results delivered.
REQ-036 Reset mid-sweep: rst_n low at idx=1 -> outputs at reset values immediately; no done; a subsequent start sweeps from idx=0.
REQ-037 Width: N=4, tt=16'hFFFF, ready=1 -> 16 transfers; ones=16 (5'b10000); done at cycle 17 after start.
